// File: rtl/axis_to_fifo_writer.sv
// axis_to_fifo_writer
//
// AXI-Stream slave that moves beats into a synchronous FIFO write port.
// tready_out is registered from the occupancy of a 2-entry skid buffer, so
// fifo_almost_full never reaches tready_out combinationally. The buffer head
// is popped into a registered write port whenever fifo_almost_full is low.
// Frames longer than MAX_FRAME_WORDS are truncated: the last kept beat is
// written with tlast forced high and the rest of the frame is discarded.
//
// Build option: define AXIS_TO_FIFO_SIDEBAND_EN to store {tlast, tkeep, tdata}
// in the FIFO word. Without it only tdata is stored and tkeep_in is unused.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   tvalid_in/tdata_in/tlast_in/tkeep_in   AXIS slave inputs
//   tready_out            registered AXIS ready
//   fifo_write_enable     registered FIFO write strobe
//   fifo_data_in          registered FIFO write data (FIFO_WIDTH bits)
//   fifo_almost_full      FIFO has >=2 free entries while low
//   fifo_full             FIFO full, used only for overflow detection
//   frame_count           complete frames written to the FIFO
//   drop_count            frames truncated for being oversize
//   overflow_error        sticky: a write was issued while fifo_full was high
//   state                 frame FSM state (debug)
//
// Handshake: a beat transfers on a rising edge where tvalid_in and tready_out
// are both high; the beat fields are don't-care on any other edge. The FIFO
// side has no ready: fifo_write_enable is a one-cycle strobe per word and the
// FIFO is trusted to accept it while fifo_almost_full was low.

module axis_to_fifo_writer #(
  parameter int DATA_SIZE       = 512,
  parameter int MAX_FRAME_WORDS = 64,
  parameter int COUNT_WIDTH     = 32,
`ifdef AXIS_TO_FIFO_SIDEBAND_EN
  localparam int FIFO_WIDTH     = DATA_SIZE + DATA_SIZE/8 + 1
`else
  localparam int FIFO_WIDTH     = DATA_SIZE
`endif
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     tvalid_in,
  input  logic [DATA_SIZE-1:0]     tdata_in,
  input  logic                     tlast_in,
  input  logic [DATA_SIZE/8-1:0]   tkeep_in,
  output logic                     tready_out,
  output logic                     fifo_write_enable,
  output logic [FIFO_WIDTH-1:0]    fifo_data_in,
  input  logic                     fifo_almost_full,
  input  logic                     fifo_full,
  output logic [COUNT_WIDTH-1:0]   frame_count,
  output logic [COUNT_WIDTH-1:0]   drop_count,
  output logic                     overflow_error,
  output logic [1:0]               state
);

  localparam int WC_WIDTH = $clog2(MAX_FRAME_WORDS + 1);
  localparam logic [WC_WIDTH-1:0] WC_ONE = WC_WIDTH'(1);
  localparam logic [WC_WIDTH-1:0] WC_MAX = WC_WIDTH'(MAX_FRAME_WORDS);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_IN_FRAME = 2'd1;
  localparam logic [1:0] ST_DROP     = 2'd2;

  logic [WC_WIDTH-1:0]   word_count;
  logic [WC_WIDTH-1:0]   beat_num;
  logic [1:0]            occ;
  logic [1:0]            occ_next;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  truncate;
  logic                  push_last;
  logic [FIFO_WIDTH-1:0] push_payload;
  // Bit FIFO_WIDTH marks the beat that completes a legal frame; frame_count
  // advances when that beat leaves the buffer.
  logic [FIFO_WIDTH:0]   new_entry;
  logic [FIFO_WIDTH:0]   entry [2];

  always_comb begin
    accept    = tvalid_in & tready_out;
    beat_num  = (state == ST_IDLE) ? WC_ONE : word_count + WC_ONE;
    truncate  = accept && (state == ST_IN_FRAME) && !tlast_in && (beat_num == WC_MAX);
    // Beats of a frame being dropped are acknowledged but never buffered.
    push      = accept && (state != ST_DROP);
    push_last = tlast_in | truncate;
    pop       = (occ != 2'd0) && !fifo_almost_full;
    occ_next  = occ + {1'b0, push} - {1'b0, pop};
  end

`ifdef AXIS_TO_FIFO_SIDEBAND_EN
  assign push_payload = {push_last, tkeep_in, tdata_in};
`else
  logic unused_sideband;
  assign push_payload    = tdata_in;
  assign unused_sideband = ^{tkeep_in, push_last};
`endif

  assign new_entry = {tlast_in, push_payload};

  // Skid buffer storage, entry[0] is the head. A push lands in the first
  // free slot after any simultaneous pop has shifted entry[1] forward.
  always_ff @(posedge clock) begin
    case ({push, pop})
      2'b10: begin
        if (occ == 2'd0) entry[0] <= new_entry;
        else             entry[1] <= new_entry;
      end
      2'b01: entry[0] <= entry[1];
      2'b11: begin
        if (occ == 2'd1) begin
          entry[0] <= new_entry;
        end else begin
          entry[0] <= entry[1];
          entry[1] <= new_entry;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tready_out        <= 1'b0;
      fifo_write_enable <= 1'b0;
      fifo_data_in      <= '0;
      frame_count       <= '0;
      drop_count        <= '0;
      overflow_error    <= 1'b0;
      occ               <= 2'd0;
      word_count        <= '0;
      state             <= ST_IDLE;
    end else begin
      occ        <= occ_next;
      tready_out <= (occ_next < 2'd2);

      if (pop) begin
        fifo_write_enable <= 1'b1;
        fifo_data_in      <= entry[0][FIFO_WIDTH-1:0];
        if (entry[0][FIFO_WIDTH]) frame_count <= frame_count + COUNT_WIDTH'(1);
      end else begin
        fifo_write_enable <= 1'b0;
      end

      if (fifo_write_enable && fifo_full) overflow_error <= 1'b1;

      if (accept) begin
        case (state)
          ST_IDLE: begin
            if (tlast_in) begin
              word_count <= '0;
            end else begin
              word_count <= WC_ONE;
              state      <= ST_IN_FRAME;
            end
          end
          ST_IN_FRAME: begin
            if (tlast_in) begin
              word_count <= '0;
              state      <= ST_IDLE;
            end else if (truncate) begin
              word_count <= beat_num;
              drop_count <= drop_count + COUNT_WIDTH'(1);
              state      <= ST_DROP;
            end else begin
              word_count <= beat_num;
            end
          end
          ST_DROP: begin
            if (tlast_in) begin
              word_count <= '0;
              state      <= ST_IDLE;
            end
          end
          default: begin
            word_count <= '0;
            state      <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_to_fifo_writer.sv
// Directed bench for axis_to_fifo_writer: hand-timed sequences for reset,
// latency, backpressure, mid-frame reset and overflow, plus a table of frame
// lengths checked against hand-computed write and counter values. A negedge
// monitor compares every FIFO write with the expected queue.

module tb_axis_to_fifo_writer;

  localparam int DATA_SIZE = 512;
  localparam int KEEP_W    = DATA_SIZE / 8;
  localparam int MAX_W     = 64;
  localparam int CW        = 32;
`ifdef AXIS_TO_FIFO_SIDEBAND_EN
  localparam int FW = DATA_SIZE + KEEP_W + 1;
`else
  localparam int FW = DATA_SIZE;
`endif

  logic                 clock;
  logic                 reset;
  logic                 tvalid_in;
  logic [DATA_SIZE-1:0] tdata_in;
  logic                 tlast_in;
  logic [KEEP_W-1:0]    tkeep_in;
  logic                 tready_out;
  logic                 fifo_write_enable;
  logic [FW-1:0]        fifo_data_in;
  logic                 fifo_almost_full;
  logic                 fifo_full;
  logic [CW-1:0]        frame_count;
  logic [CW-1:0]        drop_count;
  logic                 overflow_error;
  logic [1:0]           dut_state;

  axis_to_fifo_writer #(
    .DATA_SIZE(DATA_SIZE),
    .MAX_FRAME_WORDS(MAX_W),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .tvalid_in(tvalid_in),
    .tdata_in(tdata_in),
    .tlast_in(tlast_in),
    .tkeep_in(tkeep_in),
    .tready_out(tready_out),
    .fifo_write_enable(fifo_write_enable),
    .fifo_data_in(fifo_data_in),
    .fifo_almost_full(fifo_almost_full),
    .fifo_full(fifo_full),
    .frame_count(frame_count),
    .drop_count(drop_count),
    .overflow_error(overflow_error),
    .state(dut_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  int n_writes     = 0;
  int n_accepts    = 0;
  logic [FW-1:0] exp_q[$];

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] exp_word(input logic [DATA_SIZE-1:0] d,
                                             input logic [KEEP_W-1:0] k, input logic l);
`ifdef AXIS_TO_FIFO_SIDEBAND_EN
    return {l, k, d};
`else
    return d;
`endif
  endfunction

  function automatic logic [DATA_SIZE-1:0] rand_data();
    logic [DATA_SIZE-1:0] r;
    for (int i = 0; i < DATA_SIZE / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Every write must match the oldest expected word.
  always @(negedge clock) begin
    if (fifo_write_enable === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_write: got %0h expected no write", fifo_data_in);
      end else begin
        check("write_data", fifo_data_in, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [DATA_SIZE-1:0] d, input logic l,
                           input logic [KEEP_W-1:0] k, input bit expect_write,
                           input bit force_last);
    int waited = 0;
    @(negedge clock);
    tvalid_in = 1'b1;
    tdata_in  = d;
    tlast_in  = l;
    tkeep_in  = k;
    while (tready_out !== 1'b1 && waited < 500) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 500) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout: got tready_out=0 expected 1 within 500 cycles");
      tvalid_in = 1'b0;
    end else begin
      @(posedge clock);
      n_accepts++;
      if (expect_write) exp_q.push_back(exp_word(d, k, l | force_last));
      #1 tvalid_in = 1'b0;
    end
  endtask

  // Beats past MAX_W are dropped; beat MAX_W carries a forced tlast.
  task automatic send_frame(input int n, input bit with_last);
    for (int i = 1; i <= n; i++) begin
      send_beat(rand_data(), with_last && (i == n), {$urandom, $urandom},
                i <= MAX_W, i == MAX_W);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clock);
      t++;
    end
    repeat (3) @(negedge clock);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_tready", tready_out, 0);
    check("rst_wen", fifo_write_enable, 0);
    check("rst_data", fifo_data_in, 0);
    check("rst_frames", frame_count, 0);
    check("rst_drops", drop_count, 0);
    check("rst_overflow", overflow_error, 0);
    check("rst_state", dut_state, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int beats;
    int exp_writes;
    int exp_frames;
    int exp_drops;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int w0;
    logic [DATA_SIZE-1:0] d;
    logic [KEEP_W-1:0] kall;

    // beats (all end with tlast), writes, cumulative frame_count, drop_count
    vecs[0] = '{70, 64, 0, 1};
    vecs[1] = '{3,  3,  1, 1};
    vecs[2] = '{64, 64, 2, 1};
    vecs[3] = '{65, 64, 2, 2};
    vecs[4] = '{1,  1,  3, 2};
    vecs[5] = '{7,  7,  4, 2};

    kall             = '1;
    reset            = 1'b1;
    tvalid_in        = 1'b0;
    tdata_in         = '0;
    tlast_in         = 1'b0;
    tkeep_in         = '0;
    fifo_almost_full = 1'b0;
    fifo_full        = 1'b0;

    // Reset values, then tready rises on the first edge without reset.
    repeat (3) @(negedge clock);
    check_reset_outputs();
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", tready_out, 1);

    // 4-beat frame, back-to-back: writes appear from the second edge after
    // the first acceptance and stay contiguous.
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      check("t1_wen", fifo_write_enable, (i >= 3) ? 1 : 0);
      check("t1_ready", tready_out, 1);
      d         = DATA_SIZE'(i);
      tvalid_in = 1'b1;
      tdata_in  = d;
      tlast_in  = (i == 4);
      tkeep_in  = kall;
      @(posedge clock);
      exp_q.push_back(exp_word(d, kall, i == 4));
    end
    @(negedge clock);
    tvalid_in = 1'b0;
    check("t1_wen_b3", fifo_write_enable, 1);
    @(negedge clock);
    check("t1_wen_b4", fifo_write_enable, 1);
    check("t1_frames", frame_count, 1);
    @(negedge clock);
    check("t1_wen_idle", fifo_write_enable, 0);
    check("t1_drops", drop_count, 0);

    // Backpressure: only two beats fit while almost_full is held.
    fifo_almost_full = 1'b1;
    n_accepts        = 0;
    w0               = n_writes;
    fork
      send_frame(10, 1'b1);
      begin
        repeat (8) @(negedge clock);
        check("bp_ready_low", tready_out, 0);
        check("bp_accepts", n_accepts, 2);
        check("bp_no_writes", n_writes - w0, 0);
        fifo_almost_full = 1'b0;
      end
    join
    wait_drain();
    check("bp_writes", n_writes - w0, 10);
    check("bp_frames", frame_count, 2);

    // Reset mid-frame with two beats buffered: they must never be written.
    fifo_almost_full = 1'b1;
    send_beat(rand_data(), 1'b0, kall, 1'b0, 1'b0);
    send_beat(rand_data(), 1'b0, kall, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs();
    reset            = 1'b0;
    fifo_almost_full = 1'b0;
    w0               = n_writes;
    repeat (6) @(negedge clock);
    check("mr_no_writes", n_writes - w0, 0);
    check("mr_ready", tready_out, 1);

    // Frame-length table, including oversize and exact-limit frames.
    for (int v = 0; v < 6; v++) begin
      w0 = n_writes;
      send_frame(vecs[v].beats, 1'b1);
      wait_drain();
      check($sformatf("v%0d_writes", v), n_writes - w0, vecs[v].exp_writes);
      check($sformatf("v%0d_frames", v), frame_count, vecs[v].exp_frames);
      check($sformatf("v%0d_drops", v), drop_count, vecs[v].exp_drops);
      check($sformatf("v%0d_state", v), dut_state, 0);
    end

    // Overflow: sticky until reset.
    check("ovf_clear", overflow_error, 0);
    fifo_full = 1'b1;
    send_frame(1, 1'b1);
    wait_drain();
    check("ovf_set", overflow_error, 1);
    fifo_full = 1'b0;
    repeat (5) @(negedge clock);
    check("ovf_held", overflow_error, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("ovf_reset", overflow_error, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axis_to_fifo_writer.md
Name: axis_to_fifo_writer

Overview:
AXI-Stream slave that accepts beats from an upstream producer and writes them into a synchronous FIFO write port. It is the ingress counterpart of the FIFO-to-AXIS egress path: the same FIFO primitive and data width, but on the write side.
- Registered tready with a 2-entry skid buffer, so no combinational path exists from fifo_almost_full to tready_out.
- Frame tracking on tlast, plus an oversize-frame guard that truncates and drops the remainder of frames longer than MAX_FRAME_WORDS.

Parameters:
DATA_SIZE, 512, tdata width in bits; tkeep is DATA_SIZE/8.
MAX_FRAME_WORDS, 64, largest legal frame in beats (>=2).
COUNT_WIDTH, 32, width of frame_count and drop_count.

Ports:
clock  in  1  single system clock, all logic on rising edge
reset  in  1  synchronous, active-high
tvalid_in  in  1  AXIS beat valid
tdata_in  in  DATA_SIZE  AXIS data
tlast_in  in  1  AXIS end of frame
tkeep_in  in  DATA_SIZE/8  AXIS byte enables
tready_out  out  1  registered AXIS ready
fifo_write_enable  out  1  registered FIFO write strobe
fifo_data_in  out  FIFO_WIDTH  registered FIFO write data (FIFO_WIDTH: see Optional Feature)
fifo_almost_full  in  1  FIFO guarantees >=2 free entries while low
fifo_full  in  1  FIFO full (error detect only)
frame_count  out  COUNT_WIDTH  complete frames written
drop_count  out  COUNT_WIDTH  frames truncated for oversize
overflow_error  out  1  sticky: write issued while fifo_full=1

Behaviour:
- Reset (synchronous, takes effect at the edge where reset=1): tready_out=0, fifo_write_enable=0, fifo_data_in=0, frame_count=0, drop_count=0, overflow_error=0, skid buffer empty, word counter 0, state IDLE.
  - Reset mid-frame discards all buffered beats; no partial write is issued afterwards.
  - tready_out rises on the first edge with reset=0.
- Acceptance: a beat is taken on an edge where tvalid_in & tready_out. Beat fields are ignored when not accepted.
- Skid buffer: 2 entries, FIFO order.
  - tready_out <= (occupancy after this edge < 2).
  - The buffer never overflows. Simultaneous accept and drain leaves occupancy unchanged.
- Drain: on an edge where the buffer is non-empty and fifo_almost_full=0, the head is popped into the output register and fifo_write_enable<=1. Otherwise fifo_write_enable<=0 and fifo_data_in holds its value.
- Latency: beat accepted at edge N appears with fifo_write_enable=1 after edge N+1; the FIFO captures it at edge N+2. Sustained throughput is 1 beat/clock while fifo_almost_full=0.
- Word counter: counts accepted beats of the current frame, 1..MAX_FRAME_WORDS.
- State machine (updated on accepted beats only):
  - IDLE: first accepted beat -> IN_FRAME; if that beat has tlast, stay IDLE and count the frame.
  - IN_FRAME:
    - Beat with tlast -> IDLE; frame_count+1 when that beat drains to the FIFO.
    - Beat number MAX_FRAME_WORDS without tlast: written with tlast forced to 1; drop_count+1 -> DROP.
  - DROP: accepted beats are discarded (never enter the skid buffer; tready stays asserted); beat with tlast -> IDLE.
- A frame of exactly MAX_FRAME_WORDS with tlast on its last beat is legal: frame_count+1, no drop.
- Counters wrap at 2^COUNT_WIDTH.
- overflow_error sets on any edge with fifo_write_enable=1 and fifo_full=1. It clears only on reset.
- tvalid_in low mid-frame: the state is held indefinitely; there is no timeout.

Optional Feature:
Macro AXIS_TO_FIFO_SIDEBAND_EN.
- Defined: FIFO_WIDTH = DATA_SIZE + DATA_SIZE/8 + 1. fifo_data_in = {tlast, tkeep, tdata}, where tlast is the forced value on truncated frames.
- Undefined: FIFO_WIDTH = DATA_SIZE; only tdata is stored, and tkeep_in is ignored.
- Counters and truncation behave identically in both builds.

Test Plan:
- Reset, then one 4-beat frame (data 1..4, tlast on beat 4) with fifo_almost_full=0 -> four writes starting 2 edges after first acceptance, contiguous; frame_count=1; tready_out never drops.
- Hold fifo_almost_full=1 during a 10-beat burst -> tready_out low after 2 beats accepted, no writes; release -> remaining 8 beats written in order, none lost or duplicated.
- 70-beat frame with MAX_FRAME_WORDS=64 -> exactly 64 writes, 64th carries tlast=1 (sideband build), drop_count=1, frame_count=0. Next 3-beat frame -> frame_count=1.
- 64-beat frame with tlast on beat 64 -> 64 writes, frame_count=1, drop_count=0.
- Assert reset after beat 2 of a 5-beat frame with almost_full held high -> no further writes, all outputs at reset values; next frame processed normally.
- Force fifo_full=1 while a write is issued -> overflow_error=1, held until reset.
